// File: rtl/conv5x5.sv
// conv5x5 -- single-layer CNN accelerator for a 64x64 Q4.9 image.
//   Layer0: 5x5 zero-padded convolution + bias, round half up, ReLU, clamp
//           to 13'h0FFF, written to Layer0 RAM (csel=0, 4096 words).
//   Layer1: 2x2 stride-2 max-pool of Layer0, written to Layer1 RAM
//           (csel=1, 1024 words).
// Ports:
//   clk, reset (sync, active low)     ready/busy    host start / job running
//   iaddr, idata                      image ROM, one-cycle read latency
//   cwr, caddr_wr, cdata_wr           shared RAM write port
//   crd, caddr_rd, cdata_rd           shared RAM read port, one-cycle latency
//   csel                              0 = Layer0 RAM, 1 = Layer1 RAM
module conv5x5 #(
    parameter logic [324:0] KERNEL = {25{13'h0010}},
    parameter logic [12:0]  BIAS   = 13'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    output logic        busy,
    output logic [11:0] iaddr,
    input  logic [12:0] idata,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [12:0] cdata_wr,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [12:0] cdata_rd,
    output logic        csel
);
    typedef enum logic [2:0] {
        S_IDLE, S_L0_RD, S_L0_WR, S_L1_RD, S_L1_WR, S_DONE
    } state_t;

    // Bias in accumulator scale (Q8.18) with the rounding half-LSB folded in.
    localparam logic signed [31:0] BIAS_RND = {{10{BIAS[12]}}, BIAS, 9'd0} + 32'd256;

    state_t r_state, w_state_nx;

    // Layer0 sequencing: r_tap 0..24 issues a tap read, 25 is the drain cycle
    // where the last product lands and the result is registered for writing.
    logic [11:0]        r_pix;
    logic [4:0]         r_tap;
    logic [2:0]         r_ty, r_tx;
    logic               r_pv;
    logic [4:0]         r_ptap;
    logic signed [31:0] r_acc;

    // Layer1 sequencing: r_q 0..3 issues a window read, 4 is the drain cycle.
    logic [9:0]         r_opix;
    logic [2:0]         r_q;
    logic               r_lv, r_lfirst;
    logic signed [12:0] r_max;

    logic [11:0] r_iaddr, r_caddr_wr, r_caddr_rd;
    logic [12:0] r_cdata_wr;
    logic        r_cwr, r_crd, r_csel;

    logic signed [12:0] w_kern [25];
    for (genvar k = 0; k < 25; k++) begin : g_kern
        assign w_kern[k] = KERNEL[k*13 +: 13];
    end

    // Source pixel of the current tap; bits [7:6] nonzero means outside 0..63.
    logic signed [7:0]  w_ys, w_xs;
    logic               w_tap_ok;
    assign w_ys = $signed({2'b00, r_pix[11:6]}) + $signed({5'b00000, r_ty}) - 8'sd2;
    assign w_xs = $signed({2'b00, r_pix[5:0]})  + $signed({5'b00000, r_tx}) - 8'sd2;
    assign w_tap_ok = (w_ys[7:6] == 2'b00) && (w_xs[7:6] == 2'b00);

    logic signed [25:0] w_prod;
    logic signed [31:0] w_acc_nx, w_round, w_shr;
    logic [12:0]        w_relu;
    assign w_prod   = w_kern[r_ptap] * $signed(idata);
    assign w_acc_nx = r_pv ? r_acc + {{6{w_prod[25]}}, w_prod} : r_acc;
    assign w_round  = w_acc_nx + BIAS_RND;
    assign w_shr    = w_round >>> 9;

    always_comb begin
        w_relu = w_shr[12:0];
        if (w_shr[31])
            w_relu = 13'h0000;
        else if (w_shr > 32'sd4095)
            w_relu = 13'h0FFF;
    end

    logic signed [12:0] w_rd, w_max_nx;
    assign w_rd     = $signed(cdata_rd);
    assign w_max_nx = (r_lv && (r_lfirst || (w_rd > r_max))) ? w_rd : r_max;

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (ready) w_state_nx = S_L0_RD;
            S_L0_RD: if (r_tap == 5'd25) w_state_nx = S_L0_WR;
            S_L0_WR: w_state_nx = (r_pix == 12'hFFF) ? S_L1_RD : S_L0_RD;
            S_L1_RD: if (r_q == 3'd4) w_state_nx = S_L1_WR;
            S_L1_WR: w_state_nx = (r_opix == 10'h3FF) ? S_DONE : S_L1_RD;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix      <= '0;
            r_tap      <= '0;
            r_ty       <= '0;
            r_tx       <= '0;
            r_pv       <= 1'b0;
            r_ptap     <= '0;
            r_acc      <= '0;
            r_opix     <= '0;
            r_q        <= '0;
            r_lv       <= 1'b0;
            r_lfirst   <= 1'b0;
            r_max      <= '0;
            r_iaddr    <= '0;
            r_caddr_wr <= '0;
            r_caddr_rd <= '0;
            r_cdata_wr <= '0;
            r_cwr      <= 1'b0;
            r_crd      <= 1'b0;
            r_csel     <= 1'b0;
        end else begin
            r_pv   <= 1'b0;
            r_lv   <= 1'b0;
            r_cwr  <= 1'b0;
            r_crd  <= 1'b0;
            r_csel <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pix  <= '0;
                    r_tap  <= '0;
                    r_ty   <= '0;
                    r_tx   <= '0;
                    r_acc  <= '0;
                    r_opix <= '0;
                    r_q    <= '0;
                end
                S_L0_RD: begin
                    r_acc <= w_acc_nx;
                    if (r_tap != 5'd25) begin
                        // Out-of-range taps issue no read and add nothing.
                        r_pv   <= w_tap_ok;
                        r_ptap <= r_tap;
                        if (w_tap_ok)
                            r_iaddr <= {w_ys[5:0], w_xs[5:0]};
                        r_tap <= r_tap + 5'd1;
                        if (r_tx == 3'd4) begin
                            r_tx <= '0;
                            r_ty <= r_ty + 3'd1;
                        end else begin
                            r_tx <= r_tx + 3'd1;
                        end
                    end else begin
                        r_cwr      <= 1'b1;
                        r_caddr_wr <= r_pix;
                        r_cdata_wr <= w_relu;
                    end
                end
                S_L0_WR: begin
                    r_acc <= '0;
                    r_tap <= '0;
                    r_ty  <= '0;
                    r_tx  <= '0;
                    r_pix <= r_pix + 12'd1;
                end
                S_L1_RD: begin
                    r_max <= w_max_nx;
                    if (r_q != 3'd4) begin
                        // Window element q: row 2r+q[1], col 2c+q[0].
                        r_crd      <= 1'b1;
                        r_caddr_rd <= {r_opix[9:5], r_q[1], r_opix[4:0], r_q[0]};
                        r_lv       <= 1'b1;
                        r_lfirst   <= (r_q == 3'd0);
                        r_q        <= r_q + 3'd1;
                    end else begin
                        r_cwr      <= 1'b1;
                        r_csel     <= 1'b1;
                        r_caddr_wr <= {2'b00, r_opix};
                        r_cdata_wr <= w_max_nx;
                    end
                end
                S_L1_WR: begin
                    r_q    <= '0;
                    r_opix <= r_opix + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign iaddr    = r_iaddr;
    assign cwr      = r_cwr;
    assign caddr_wr = r_caddr_wr;
    assign cdata_wr = r_cdata_wr;
    assign crd      = r_crd;
    assign caddr_rd = r_caddr_rd;
    assign csel     = r_csel;
endmodule

// File: tb/tb_conv5x5.sv
// Bench for conv5x5: three instances (default kernel, saturating kernel,
// ramp kernel) each with its own image ROM and Layer0/Layer1 RAM models.
module tb_conv5x5;
    function automatic logic [324:0] ramp_kern();
        logic [324:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) v[k*13 +: 13] = 13'(k + 1);
        return v;
    endfunction

    localparam logic [324:0] K_SAT = {25{13'h0200}};
    localparam logic [324:0] K_IMP = ramp_kern();

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [3];
    logic        ready    [3];
    logic        busy     [3];
    logic [11:0] iaddr    [3];
    logic [12:0] idata    [3];
    logic        cwr      [3];
    logic [11:0] caddr_wr [3];
    logic [12:0] cdata_wr [3];
    logic        crd      [3];
    logic [11:0] caddr_rd [3];
    logic [12:0] cdata_rd [3];
    logic        csel     [3];

    logic [12:0] rom [3][4096];
    logic [12:0] l0  [3][4096];
    logic [12:0] l1  [3][1024];
    int          exp0 [3][4096];
    int          exp1 [3][1024];

    int n_wr0[3], n_wr1[3], n_fall[3], n_viol[3];
    logic busy_q[3];
    int n_chk = 0, n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_mem
        assign idata[g]    = rom[g][iaddr[g]];
        assign cdata_rd[g] = csel[g] ? l1[g][caddr_rd[g][9:0]] : l0[g][caddr_rd[g]];
    end

    conv5x5 u_dut0 (
        .clk(clk), .reset(rst_n[0]), .ready(ready[0]), .busy(busy[0]),
        .iaddr(iaddr[0]), .idata(idata[0]), .cwr(cwr[0]), .caddr_wr(caddr_wr[0]),
        .cdata_wr(cdata_wr[0]), .crd(crd[0]), .caddr_rd(caddr_rd[0]),
        .cdata_rd(cdata_rd[0]), .csel(csel[0]));
    conv5x5 #(.KERNEL(K_SAT)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .ready(ready[1]), .busy(busy[1]),
        .iaddr(iaddr[1]), .idata(idata[1]), .cwr(cwr[1]), .caddr_wr(caddr_wr[1]),
        .cdata_wr(cdata_wr[1]), .crd(crd[1]), .caddr_rd(caddr_rd[1]),
        .cdata_rd(cdata_rd[1]), .csel(csel[1]));
    conv5x5 #(.KERNEL(K_IMP)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .ready(ready[2]), .busy(busy[2]),
        .iaddr(iaddr[2]), .idata(idata[2]), .cwr(cwr[2]), .caddr_wr(caddr_wr[2]),
        .cdata_wr(cdata_wr[2]), .crd(crd[2]), .caddr_rd(caddr_rd[2]),
        .cdata_rd(cdata_rd[2]), .csel(csel[2]));

    // RAM models and protocol monitor.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            busy_q[i] <= busy[i];
            if (busy_q[i] && !busy[i]) n_fall[i] <= n_fall[i] + 1;
            if (cwr[i]) begin
                if (csel[i]) begin
                    l1[i][caddr_wr[i][9:0]] <= cdata_wr[i];
                    n_wr1[i] <= n_wr1[i] + 1;
                end else begin
                    l0[i][caddr_wr[i]] <= cdata_wr[i];
                    n_wr0[i] <= n_wr0[i] + 1;
                end
            end
            if ((cwr[i] && crd[i]) || ((cwr[i] || crd[i]) && !busy[i]) ||
                (crd[i] && csel[i]) || (cwr[i] && csel[i] && caddr_wr[i] > 12'd1023))
                n_viol[i] <= n_viol[i] + 1;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Reference: direct arithmetic on the image with signed ints.
    task automatic run_model(input int i, input int w[25]);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                int acc = 0;
                for (int dy = -2; dy <= 2; dy++)
                    for (int dx = -2; dx <= 2; dx++)
                        if (r + dy >= 0 && r + dy < 64 && c + dx >= 0 && c + dx < 64) begin
                            int px = int'(rom[i][(r + dy) * 64 + c + dx]);
                            if (px >= 4096) px -= 8192;
                            acc += px * w[(dy + 2) * 5 + dx + 2];
                        end
                acc = (acc + 256) >>> 9;
                if (acc < 0) acc = 0;
                if (acc > 4095) acc = 4095;
                exp0[i][r * 64 + c] = acc;
            end
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                int m = 0;
                for (int q = 0; q < 4; q++) begin
                    int v = exp0[i][(2 * r + q / 2) * 64 + 2 * c + q % 2];
                    if (v > m) m = v;
                end
                exp1[i][r * 32 + c] = m;
            end
    endtask

    task automatic check_job(input int i, input string tag, input int s0, input int s1,
                             input int sf, input int sv);
        int bad0 = 0, bad1 = 0;
        for (int a = 0; a < 4096; a++)
            if (int'(l0[i][a]) != exp0[i][a]) begin
                if (bad0 == 0)
                    $display("  %s first layer0 diff at %0d: dut %h model %h", tag, a, l0[i][a], exp0[i][a]);
                bad0++;
            end
        for (int a = 0; a < 1024; a++)
            if (int'(l1[i][a]) != exp1[i][a]) begin
                if (bad1 == 0)
                    $display("  %s first layer1 diff at %0d: dut %h model %h", tag, a, l1[i][a], exp1[i][a]);
                bad1++;
            end
        check({tag, " layer0 bad words"}, bad0, 0);
        check({tag, " layer1 bad words"}, bad1, 0);
        check({tag, " csel0 writes"}, n_wr0[i] - s0, 4096);
        check({tag, " csel1 writes"}, n_wr1[i] - s1, 1024);
        check({tag, " busy falls"}, n_fall[i] - sf, 1);
        check({tag, " strobe violations"}, n_viol[i] - sv, 0);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((busy[0] || busy[1] || busy[2]) && cyc < 130000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " finished within budget"}, int'(cyc < 130000), 1);
        @(negedge clk);
    endtask

    task automatic start0(input string tag);
        repeat (2) @(negedge clk);
        ready[0] = 1'b1;
        @(negedge clk);
        check({tag, " busy after ready"}, int'(busy[0]), 1);
        ready[0] = 1'b0;
    endtask

    typedef struct {
        int    inst;
        int    layer;
        int    addr;
        int    want;
        string name;
    } vec_t;

    vec_t vt [18];
    int   wdef[25], wsat[25], wimp[25];

    initial begin
        int s0, s1, sf, sv;
        vt[0]  = '{0, 0, 0,           'h090, "const L0(0,0)"};
        vt[1]  = '{0, 0, 1,           'h0C0, "const L0(0,1)"};
        vt[2]  = '{0, 0, 10,          'h0F0, "const L0(0,10)"};
        vt[3]  = '{0, 0, 65,          'h100, "const L0(1,1)"};
        vt[4]  = '{0, 0, 30*64+30,    'h190, "const L0(30,30)"};
        vt[5]  = '{0, 0, 4095,        'h090, "const L0(63,63)"};
        vt[6]  = '{0, 1, 0,           'h100, "const L1[0]"};
        vt[7]  = '{0, 1, 33,          'h190, "const L1[33]"};
        vt[8]  = '{1, 0, 0,           'hFFF, "sat L0(0,0)"};
        vt[9]  = '{1, 0, 2080,        'hFFF, "sat L0 interior"};
        vt[10] = '{1, 1, 1023,        'hFFF, "sat L1[1023]"};
        vt[11] = '{2, 0, 8*64+8,      25,    "imp L0(8,8)"};
        vt[12] = '{2, 0, 12*64+12,    1,     "imp L0(12,12)"};
        vt[13] = '{2, 0, 10*64+10,    13,    "imp L0(10,10)"};
        vt[14] = '{2, 0, 9*64+11,     17,    "imp L0(9,11)"};
        vt[15] = '{2, 0, 10*64+13,    0,     "imp L0(10,13)"};
        vt[16] = '{2, 0, 0,           0,     "imp L0(0,0)"};
        vt[17] = '{2, 1, 4*32+4,      25,    "imp L1[132]"};

        for (int k = 0; k < 25; k++) begin
            wdef[k] = 16;
            wsat[k] = 512;
            wimp[k] = k + 1;
        end
        for (int a = 0; a < 4096; a++) begin
            rom[0][a] = 13'h0200;
            rom[1][a] = 13'h0FFF;
            rom[2][a] = (a == 10*64+10) ? 13'h0200 : 13'h0000;
        end
        run_model(0, wdef);
        run_model(1, wsat);
        run_model(2, wimp);

        // Reset held with ready high; no strobes, no busy.
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            ready[i] = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            check("reset busy", int'(busy[0]), 0);
            check("reset strobes", int'(cwr[0] | crd[0] | csel[0]), 0);
        end
        check("reset addresses", int'(iaddr[0] | caddr_wr[0] | caddr_rd[0]), 0);
        check("reset cdata_wr", int'(cdata_wr[0]), 0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("inst%0d busy after reset release", i), int'(busy[i]), 1);
            ready[i] = 1'b0;
        end
        wait_idle("phase1");
        check_job(0, "const", 0, 0, 0, 0);
        check_job(1, "sat", 0, 0, 0, 0);
        check_job(2, "impulse", 0, 0, 0, 0);
        for (int v = 0; v < 18; v++)
            check(vt[v].name,
                  vt[v].layer == 0 ? int'(l0[vt[v].inst][vt[v].addr])
                                   : int'(l1[vt[v].inst][vt[v].addr]),
                  vt[v].want);

        // All -1.0 image: ReLU zeroes everything.
        for (int a = 0; a < 4096; a++) rom[0][a] = 13'h1E00;
        run_model(0, wdef);
        s0 = n_wr0[0]; s1 = n_wr1[0]; sf = n_fall[0]; sv = n_viol[0];
        start0("negative");
        wait_idle("negative");
        check_job(0, "negative", s0, s1, sf, sv);

        // Random image, job aborted by reset after 1000 cycles, then rerun.
        for (int a = 0; a < 4096; a++)
            rom[0][a] = ($urandom_range(0, 3) == 0) ? 13'(8192 - $urandom_range(1, 1024))
                                                    : 13'($urandom_range(0, 4095));
        run_model(0, wdef);
        start0("abort");
        repeat (1000) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        check("abort busy in reset", int'(busy[0]), 0);
        check("abort strobes in reset", int'(cwr[0] | crd[0]), 0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        check("abort stays idle", int'(busy[0]), 0);
        s0 = n_wr0[0]; s1 = n_wr1[0]; sf = n_fall[0]; sv = n_viol[0];
        start0("random");
        wait_idle("random");
        check_job(0, "random", s0, s1, sf, sv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv5x5.md
Name: conv5x5

Overview:
- Single-layer CNN accelerator for a 64x64 image of 13-bit signed Q4.9 pixels read from external image ROM.
- Layer 0: 5x5 convolution with zero padding, plus bias, round, ReLU and saturation. Results (4096 words) go to external Layer0 RAM.
- Layer 1: 2x2 stride-2 max-pool of Layer0. Results (1024 words) go to external Layer1 RAM.
- Sits between the host handshake (ready/busy) and two external memories sharing one read/write port pair selected by csel.

Parameters:
- KERNEL, default 25 copies of 13'h0010 (1/32 each), packed signed Q4.9 weights; tap (dy,dx), dy,dx in -2..2, is at index (dy+2)*5+(dx+2), index 0 in LSBs.
- BIAS, default 13'h0000, signed Q4.9 bias.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- ready  in  1  host has image available, start request
- busy  out  1  job in progress
- iaddr  out  12  image address, row*64+col
- idata  in  13  image pixel, valid before the next rising edge after iaddr changes
- cwr  out  1  write strobe, memory writes at the rising edge
- caddr_wr  out  12  write address
- cdata_wr  out  13  write data
- crd  out  1  read strobe
- caddr_rd  out  12  read address
- cdata_rd  in  13  read data, valid before the next rising edge after caddr_rd/crd
- csel  out  1  0 = Layer0 RAM, 1 = Layer1 RAM, for both read and write

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to IDLE; busy=0, cwr=0, crd=0, csel=0; all addresses and cdata_wr =0; accumulator cleared.
  - Reset mid-job aborts the job immediately.
- IDLE: when ready=1 at a rising edge, go to L0_RD and raise busy at that edge. The host may lower ready any time afterwards; ready is ignored until the next IDLE.
- Memory timing: any address driven after edge t is sampled at edge t+1 (one-cycle read latency). Pipeline the address and accumulate stages accordingly.
- L0_RD, per output pixel (r,c), raster order r=0..63, c=0..63:
  - Step through the 25 taps in kernel index order.
  - In-range tap (0<=r+dy<64, 0<=c+dx<64): iaddr=(r+dy)*64+(c+dx); accumulate idata*w.
  - Out-of-range tap: contributes 0 and is skipped with no wait; idata is ignored.
- Layer0 arithmetic:
  - Each product is 13x13 signed, Q8.18.
  - Accumulator at least 32-bit signed.
  - Add BIAS sign-extended and shifted left by 9.
  - Round half up: add 1<<8, arithmetic shift right 9.
  - ReLU: negative gives 0; a value above 13'h0FFF saturates to 13'h0FFF.
- L0_WR: one cycle with cwr=1, csel=0, caddr_wr=r*64+c, cdata_wr=result. Clear the accumulator, advance the pixel. After pixel 4095, go to L1_RD.
- L1_RD, per output (r,c), r,c=0..31:
  - crd=1, csel=0; read Layer0 at (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - Keep the signed maximum.
- L1_WR: one cycle with cwr=1, csel=1, caddr_wr=r*32+c, cdata_wr=max. After address 1023, go to DONE.
- Strobe exclusivity: cwr and crd are never both 1; crd=0 outside L1_RD; cwr=0 outside the WR states.
- DONE: one cycle with busy=0, then IDLE. All writes complete before busy falls.
- The block never writes an address outside 0..4095 / 0..1023.

Test Plan:
- Reset/handshake: hold reset=0 with ready=1 for 3 cycles, release -> busy=1 within 1 cycle; cwr=crd=0 while in reset.
- Constant image, all 13'h0200, default params -> Layer0 interior 13'h0190, corner (0,0) 13'h0090, (0,1) 13'h00C0, edge (0,10) 13'h00F0, (1,1) 13'h0100; Layer1[0]=13'h0100, Layer1[33]=13'h0190.
- All-negative image 13'h1E00 (-1.0) -> all Layer0 and Layer1 outputs 13'h0000 (ReLU).
- Saturation: image 13'h0FFF with KERNEL all 13'h0200 -> every Layer0 word 13'h0FFF.
- Impulse: pixel (10,10)=13'h0200, others 0, KERNEL index k = k+1 (LSB units) -> Layer0(10+dy,10+dx) equals the rounded weight for tap (-dy,-dx); check correct tap orientation and zero elsewhere.
- Reset mid-Layer0 (after 1000 cycles) then restart -> full correct output; busy falls exactly once per job; 4096 writes with csel=0 and 1024 with csel=1.
